// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC mux and req/ack instruction-memory fetch.
// Optional misaligned-target trap to EXC_VECTOR when ALIGN_CHECK_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] RD1,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPLUS4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic        exc_misalign
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StValid = 2'd2
    } state_t;

    localparam logic [1:0] NpcPlus4  = 2'b00;
    localparam logic [1:0] NpcBranch = 2'b01;
    localparam logic [1:0] NpcJump   = 2'b10;
    localparam logic [1:0] NpcReg    = 2'b11;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;

    logic        w_take_ack;
    logic        w_take_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic [31:0] w_pc_target;
    logic [31:0] w_pc_d;

    always_comb begin
        w_state_next   = r_state;
        w_take_ack     = 1'b0;
        w_take_advance = 1'b0;
        case (r_state)
            StIdle: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    w_take_ack   = 1'b1;
                    w_state_next = StValid;
                end
            end
            StValid: begin
                if (advance) begin
                    w_take_advance = 1'b1;
                    w_state_next   = StFetch;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_npc = w_pc_plus4;
        unique case (NPCOp)
            NpcPlus4:  w_npc = w_pc_plus4;
            NpcBranch: w_npc = w_pc_plus4 + w_br_off;
            NpcJump:   w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            NpcReg:    w_npc = RD1;
            default:   w_npc = w_pc_plus4;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    logic w_misalign;
    logic r_exc_misalign;

    assign w_misalign  = |w_npc[1:0];
    assign w_pc_target = w_misalign ? EXC_VECTOR : w_npc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_misalign <= 1'b0;
        end else begin
            r_exc_misalign <= w_take_advance & w_misalign;
        end
    end

    assign exc_misalign = r_exc_misalign;
`else
    // Low address bits are dropped silently without the alignment check.
    assign w_pc_target  = w_npc & ~32'd3;
    assign exc_misalign = 1'b0;
`endif

    assign w_pc_d = w_take_advance ? w_pc_target : r_pc;

    // Request and address are registered from next-state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_d;
            r_instr_valid <= (w_state_next == StValid);
            r_imem_req    <= (w_state_next == StFetch);
            r_imem_addr   <= w_pc_d;
            if (w_take_ack) begin
                r_instr <= imem_rdata;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign PC          = r_pc;
    assign PCPLUS4     = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign Op          = r_instr[31:26];
    assign Funct       = r_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized fetch/advance traffic
// against a behavioural next-PC model. Honours ALIGN_CHECK_EN when defined.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    logic        clk;
    logic        rst;
    logic [1:0]  NPCOp;
    logic [31:0] RD1;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PCPLUS4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        exc_misalign;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .NPCOp        (NPCOp),
        .RD1          (RD1),
        .advance      (advance),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .PCPLUS4      (PCPLUS4),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .Op           (Op),
        .Funct        (Funct),
        .exc_misalign (exc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next PC straight from the ISA rules, using plain integer arithmetic.
    function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic [31:0] pc,
                                            input logic [31:0] ins, input logic [31:0] rd1);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(ins[15:0]));
        case (op)
            2'd0:    return seq;
            2'd1:    return seq + 32'(off * 4);
            2'd2:    return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
            default: return rd1;
        endcase
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        advance  = 1'b0;
        imem_ack = 1'b0;
        tick();
        tick();
        check_eq("rst_pc", PC, RESET_PC);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_exc", 32'(exc_misalign), 32'd0);
        rst  = 1'b0;
        m_pc = RESET_PC;
    endtask

    task automatic do_fetch(input int waits, input logic [31:0] data);
        int guard;
        guard = 0;
        while (imem_req !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        check_eq("req_seen", 32'(imem_req), 32'd1);
        check_eq("fetch_addr", imem_addr, m_pc);
        check_eq("fetch_pc", PC, m_pc);
        check_eq("fetch_valid_lo", 32'(instr_valid), 32'd0);
        for (int i = 0; i < waits; i++) begin
            advance = 1'($urandom_range(0, 1));
            NPCOp   = 2'($urandom_range(0, 3));
            RD1     = $urandom;
            tick();
            check_eq("req_hold", 32'(imem_req), 32'd1);
            check_eq("addr_hold", imem_addr, m_pc);
            check_eq("pc_hold", PC, m_pc);
            check_eq("exc_lo", 32'(exc_misalign), 32'd0);
        end
        advance    = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = data;
        check_eq("valid_hi", 32'(instr_valid), 32'd1);
        check_eq("instr", instr, data);
        check_eq("op", 32'(Op), 32'(data[31:26]));
        check_eq("funct", 32'(Funct), 32'(data[5:0]));
        check_eq("pcplus4", PCPLUS4, m_pc + 32'd4);
        check_eq("req_lo", 32'(imem_req), 32'd0);
        check_eq("exc_lo_ack", 32'(exc_misalign), 32'd0);
    endtask

    task automatic do_adv(input logic [1:0] op, input logic [31:0] rd1, input int idle);
        logic [31:0] npc;
        logic [31:0] nxt;
        logic        exc;
        for (int i = 0; i < idle; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            NPCOp      = 2'($urandom_range(0, 3));
            tick();
            check_eq("idle_instr", instr, m_instr);
            check_eq("idle_valid", 32'(instr_valid), 32'd1);
            check_eq("idle_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        NPCOp    = op;
        RD1      = rd1;
        advance  = 1'b1;
        npc      = ref_npc(op, m_pc, m_instr, rd1);
`ifdef ALIGN_CHECK_EN
        exc = (npc[1:0] != 2'd0);
        nxt = exc ? EXC_VECTOR : npc;
`else
        exc = 1'b0;
        nxt = npc - 32'(npc % 32'd4);
`endif
        tick();
        advance = 1'b0;
        m_pc    = nxt;
        check_eq("adv_valid", 32'(instr_valid), 32'd0);
        check_eq("adv_req", 32'(imem_req), 32'd1);
        check_eq("adv_addr", imem_addr, m_pc);
        check_eq("adv_pc", PC, m_pc);
        check_eq("adv_exc", 32'(exc_misalign), 32'(exc));
    endtask

    task automatic do_reset_mid_fetch();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        advance    = 1'b1;
        tick();
        check_eq("mid_instr", instr, 32'd0);
        check_eq("mid_valid", 32'(instr_valid), 32'd0);
        check_eq("mid_pc", PC, RESET_PC);
        check_eq("mid_req", 32'(imem_req), 32'd0);
        rst     = 1'b0;
        advance = 1'b0;
        tick();
        imem_ack = 1'b0;
        m_pc     = RESET_PC;
        check_eq("mid_instr_after", instr, 32'd0);
        check_eq("mid_valid_after", 32'(instr_valid), 32'd0);
        check_eq("mid_req_after", 32'(imem_req), 32'd1);
        check_eq("mid_addr_after", imem_addr, RESET_PC);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] rd1;
        NPCOp      = 2'd0;
        RD1        = 32'd0;
        advance    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        m_instr    = 32'd0;

        do_reset();
        do_fetch(3, 32'h2008_0005);
        check_eq("first_op", 32'(Op), 32'h08);

        do_adv(2'd0, 32'd0, 0);
        check_eq("seq_addr", imem_addr, 32'h0000_3004);
        do_fetch(1, 32'h0000_0020);
        check_eq("seq_pcplus4", PCPLUS4, 32'h0000_3008);

        do_adv(2'd3, 32'h0000_3010, 1);
        do_fetch(0, 32'h1109_FFFC);
        do_adv(2'd1, 32'd0, 0);
        check_eq("branch_pc", PC, 32'h0000_3004);

        do_fetch(2, 32'h0C00_0C10);
        do_adv(2'd2, 32'd0, 0);
        check_eq("jump_pc", PC, 32'h0000_3040);
        do_fetch(0, $urandom);
        do_adv(2'd3, 32'h0000_3020, 2);
        check_eq("jr_pc", PC, 32'h0000_3020);

        do_fetch(1, $urandom);
        do_adv(2'd3, 32'h0000_3022, 0);
`ifdef ALIGN_CHECK_EN
        check_eq("misalign_pc", PC, 32'h0000_4180);
        check_eq("misalign_exc", 32'(exc_misalign), 32'd1);
`else
        check_eq("misalign_pc", PC, 32'h0000_3020);
        check_eq("misalign_exc", 32'(exc_misalign), 32'd0);
`endif
        do_fetch(1, $urandom);

        do_adv(2'd3, 32'hFFFF_FFFC, 0);
        do_fetch(0, $urandom);
        do_adv(2'd0, 32'd0, 0);
        check_eq("wrap_pc", PC, 32'd0);

        do_reset_mid_fetch();
        do_fetch(2, 32'h2008_0005);

        for (int it = 0; it < 60; it++) begin
            op  = 2'($urandom_range(0, 3));
            rd1 = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                rd1 = rd1 & ~32'd3;
            end
            do_adv(op, rd1, $urandom_range(0, 2));
            do_fetch($urandom_range(0, 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
